// File: rtl/uart_rx_byte_if.sv
// Byte-stream side of uart_rx_byte: serial line in, received byte and status pulses out.
// master = line driver / byte consumer, slave = the receiver itself.
interface uart_rx_byte_if;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (
      output rx,
      input  data, data_valid, frame_err, parity_err, busy
   );

   modport slave (
      input  rx,
      output data, data_valid, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error detection.
// Define UART_RX_PARITY_EN to switch the frame to 8E1 with a parity check.
module uart_rx_byte #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_byte_if.slave  bus
);

   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bidx;
   logic [7:0]      r_shreg;
   logic [7:0]      r_data;
   logic            r_dv;
   logic            r_fe;

   logic            w_rx_s;
   logic            w_cnt_end;
   logic            w_cnt_half;
   logic            w_cnt_clr;
   logic            w_bidx_clr;
   logic            w_shift;
   logic            w_dv;
   logic            w_fe;

`ifdef UART_RX_PARITY_EN
   logic            r_par;
   logic            r_pe;
   logic            w_par_smp;
   logic            w_pe;
   logic            w_par_bad;
   assign w_par_bad = (^r_shreg) ^ r_par;
`endif

   assign w_rx_s     = r_sync2;
   assign w_cnt_end  = (r_cnt == CNT_LAST);
   assign w_cnt_half = (r_cnt == CNT_HALF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (!w_rx_s) w_next = S_START;
         S_START:     if (w_cnt_half) w_next = w_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:      if (w_cnt_end && r_bidx == 3'd7) w_next = S_PARITY;
         S_PARITY:    if (w_cnt_end) w_next = S_STOP;
`else
         S_DATA:      if (w_cnt_end && r_bidx == 3'd7) w_next = S_STOP;
`endif
         // A low stop bit parks in WAIT_HIGH so a break never looks like a new start.
         S_STOP:      if (w_cnt_end) w_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_clr  = 1'b0;
      w_bidx_clr = 1'b1;
      w_shift    = 1'b0;
      w_dv       = 1'b0;
      w_fe       = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp  = 1'b0;
      w_pe       = 1'b0;
`endif
      case (r_state)
         S_IDLE:      w_cnt_clr = 1'b1;
         S_START:     w_cnt_clr = w_cnt_half;
         S_DATA: begin
            w_bidx_clr = 1'b0;
            if (w_cnt_end) begin
               w_cnt_clr = 1'b1;
               w_shift   = 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_end) begin
               w_cnt_clr = 1'b1;
               w_par_smp = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_cnt_end) begin
               w_cnt_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (!w_rx_s)        w_fe = 1'b1;
               else if (w_par_bad) w_pe = 1'b1;
               else                w_dv = 1'b1;
`else
               if (!w_rx_s) w_fe = 1'b1;
               else         w_dv = 1'b1;
`endif
            end
         end
         S_WAIT_HIGH: w_cnt_clr = 1'b1;
         default:     w_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_bidx  <= '0;
         r_shreg <= '0;
         r_data  <= '0;
         r_dv    <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
         if (w_bidx_clr)   r_bidx <= '0;
         else if (w_shift) r_bidx <= r_bidx + 1'b1;
         if (w_shift) r_shreg[r_bidx] <= w_rx_s;
         if (w_dv)    r_data <= r_shreg;
         r_dv <= w_dv;
         r_fe <= w_fe;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par <= 1'b0;
         r_pe  <= 1'b0;
      end else begin
         if (w_par_smp) r_par <= w_rx_s;
         r_pe <= w_pe;
      end
   end
   assign bus.parity_err = r_pe;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.data       = r_data;
   assign bus.data_valid = r_dv;
   assign bus.frame_err  = r_fe;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: frames are predicted from their bit content and checked by a monitor.
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.
module tb_uart_rx_byte;

   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS    = 10;
   localparam bit PAR_EN   = 1'b1;
`else
   localparam int NBITS    = 9;
   localparam bit PAR_EN   = 1'b0;
`endif

   localparam int K_DV = 0;
   localparam int K_FE = 1;
   localparam int K_PE = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t mon_e;
   int   mon_kind;
   logic [7:0] model_data = 8'h00;

   bit   meas_gap = 1'b0;
   int   gap_run  = 0;
   int   gap_max  = 0;

   uart_rx_byte_if u_if ();

   uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (u_if.data_valid || u_if.frame_err || u_if.parity_err)) begin
         chk("dv_fe_exclusive", int'(u_if.data_valid && u_if.frame_err), 0);
         mon_kind = u_if.data_valid ? K_DV : (u_if.frame_err ? K_FE : K_PE);
         if (q.size() == 0) begin
            chk("unexpected_pulse_kind", mon_kind, -1);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_kind", mon_kind, mon_e.kind);
            chk("pulse_data", int'(u_if.data), int'(mon_e.data));
            chk("pulse_cycle", cyc, mon_e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (meas_gap) begin
         if (!u_if.busy) gap_run++;
         else begin
            if (gap_run > gap_max) gap_max = gap_run;
            gap_run = 0;
         end
      end
   end

   function automatic logic even_par(input logic [7:0] b);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(b[i]);
      return logic'(n % 2);
   endfunction

   // Called at a negedge; predicts the outcome, drives the frame, then idles high for gap cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b, input int gap);
      exp_t e;
      e.cyc = cyc + 1 + 2 + HALF + NBITS * CPB;
      if (!stop_b) begin
         e.kind = K_FE;
         e.data = model_data;
      end else if (PAR_EN && (even_par(b) != par_b)) begin
         e.kind = K_PE;
         e.data = model_data;
      end else begin
         e.kind = K_DV;
         e.data = b;
         model_data = b;
      end
      q.push_back(e);
      u_if.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         u_if.rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (PAR_EN) begin
         u_if.rx = par_b;
         repeat (CPB) @(negedge clk);
      end
      u_if.rx = stop_b;
      repeat (CPB) @(negedge clk);
      if (gap > 0) begin
         u_if.rx = 1'b1;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 40 * CPB) begin
         @(negedge clk);
         n++;
      end
      chk(name, q.size(), 0);
   endtask

   initial begin
      logic [7:0] b;
      logic       sb;
      logic       pb;
      int         gap;
      bit         seen_busy;

      rst_n    = 1'b0;
      u_if.rx  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", int'(u_if.data), 0);
      chk("rst_data_valid", int'(u_if.data_valid), 0);
      chk("rst_frame_err", int'(u_if.frame_err), 0);
      chk("rst_parity_err", int'(u_if.parity_err), 0);
      chk("rst_busy", int'(u_if.busy), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: single 'T'
      send_frame(8'h54, 1'b1, even_par(8'h54), CPB);
      drain("t1_drain");
      chk("t1_data_hold", int'(u_if.data), 8'h54);

      // 2: "12" back to back
      gap_run  = 0;
      gap_max  = 0;
      meas_gap = 1'b1;
      send_frame(8'h31, 1'b1, even_par(8'h31), 0);
      send_frame(8'h32, 1'b1, even_par(8'h32), 2);
      meas_gap = 1'b0;
      drain("t2_drain");
      chk("t2_busy_gap_ok", int'(gap_max <= CPB - HALF), 1);

      // 3: short glitch
      u_if.rx = 1'b0;
      repeat (3) @(negedge clk);
      u_if.rx = 1'b1;
      seen_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (u_if.busy) seen_busy = 1'b1;
      end
      chk("t3_busy_seen", int'(seen_busy), 1);
      chk("t3_busy_idle", int'(u_if.busy), 0);
      repeat (2 * CPB) @(negedge clk);
      chk("t3_no_pulse", q.size(), 0);

      // 4: framing error followed by a break, then a good byte
      send_frame(8'h0A, 1'b0, even_par(8'h0A), 0);
      repeat (40) @(negedge clk);
      chk("t4_busy_in_break", int'(u_if.busy), 1);
      drain("t4_fe_drain");
      u_if.rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("t4_busy_after_break", int'(u_if.busy), 0);
      chk("t4_data_kept", int'(u_if.data), 8'h32);
      send_frame(8'h0A, 1'b1, even_par(8'h0A), CPB);
      drain("t4_drain");

      // 5: reset in the middle of data bit 4
      b = 8'h3A;
      u_if.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         u_if.rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      u_if.rx = b[4];
      repeat (HALF) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_data", int'(u_if.data), 0);
      chk("t5_rst_busy", int'(u_if.busy), 0);
      chk("t5_rst_dv", int'(u_if.data_valid), 0);
      u_if.rx = 1'b1;
      model_data = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("t5_no_pulse", q.size(), 0);
      send_frame(8'h3A, 1'b1, even_par(8'h3A), CPB);
      drain("t5_drain");

`ifdef UART_RX_PARITY_EN
      // 6: wrong then right parity
      send_frame(8'h35, 1'b1, 1'b1, CPB);
      send_frame(8'h35, 1'b1, 1'b0, CPB);
      drain("t6_drain");
`endif

      // random frames, including bad stop and (with parity) bad parity bits
      for (int n = 0; n < 24; n++) begin
         b   = 8'($urandom);
         sb  = ($urandom_range(0, 4) != 0);
         pb  = even_par(b) ^ ($urandom_range(0, 3) == 0);
         gap = sb ? int'($urandom_range(0, CPB)) : CPB + int'($urandom_range(0, CPB));
         send_frame(b, sb, pb, gap);
      end
      u_if.rx = 1'b1;
      drain("rand_drain");
      chk("final_data", int'(u_if.data), int'(model_data));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
